// File: rtl/gpio_event_logger.sv
// Watches the SoC gpio/gpio1 ports, logs every change with a timestamp into a
// show-ahead FIFO and decodes the firmware end-of-test handshake into sticky flags.
module gpio_event_logger #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned TS_W       = 24,
  parameter logic [31:0] DONE_MAGIC = 32'hD0D0_CAFE,
  parameter logic [31:0] PASS_VALUE = 32'h0000_0001
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              gpio,
  input  logic [31:0]              gpio1,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_W-1:0]          ev_ts,
  output logic [1:0]               ev_src,
  output logic [31:0]              ev_gpio,
  output logic [31:0]              ev_gpio1,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              drop_cnt,
  output logic                     test_done,
  output logic                     test_pass
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [TS_W-1:0] TS_ONE  = 1;
  localparam logic [PW:0]     PTR_ONE = 1;

  typedef struct packed {
    logic [TS_W-1:0] ts;
    logic [1:0]      src;
    logic [31:0]     g;
    logic [31:0]     g1;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          head;
  logic [PW:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [TS_W-1:0] ts_q, ts_d;
  logic [31:0]     prev_gpio_q, prev_gpio1_q;
  logic            overflow_q, overflow_d;
  logic [15:0]     drop_cnt_q, drop_cnt_d;
  logic            done_q, done_d, pass_q, pass_d;
  logic [1:0]      chg;
  logic            empty, full, pop, push, drop;

  always_comb begin
    chg   = {gpio1 != prev_gpio1_q, gpio != prev_gpio_q};
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    pop   = !empty && ev_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push  = (chg != 2'b00) && (!full || pop);
    drop  = (chg != 2'b00) && full && !pop;

    wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    ts_d       = (ts_q == '1) ? ts_q : ts_q + TS_ONE;
    overflow_d = overflow_q | drop;
    drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;

    done_d = done_q;
    pass_d = pass_q;
    if (!done_q && gpio == DONE_MAGIC) begin
      done_d = 1'b1;
      pass_d = (gpio1 == PASS_VALUE);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ts_q         <= '0;
      prev_gpio_q  <= '0;
      prev_gpio1_q <= '0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ts_q         <= ts_d;
      prev_gpio_q  <= gpio;
      prev_gpio1_q <= gpio1;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers alone define which
  // entries are meaningful, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[PW-1:0]] <= '{ts: ts_q, src: chg, g: gpio, g1: gpio1};
  end

  // Head data is forced to zero while empty so the outputs read 0 in reset.
  assign head      = empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
  assign ev_valid  = !empty;
  assign ev_ts     = head.ts;
  assign ev_src    = head.src;
  assign ev_gpio   = head.g;
  assign ev_gpio1  = head.g1;
  assign level     = wr_ptr_q - rd_ptr_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
  assign test_done = done_q;
  assign test_pass = pass_q;

endmodule

// File: tb/tb_gpio_event_logger.sv
// Self-checking bench for gpio_event_logger: a stimulus table plus hand-written
// sequences, with a queue-based scoreboard of expected events.
module tb_gpio_event_logger;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TS_W  = 24;
  localparam logic [31:0] MAGIC = 32'hD0D0_CAFE;
  localparam logic [31:0] PASSV = 32'h0000_0001;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       gpio = '0, gpio1 = '0;
  logic              ev_ready = 1'b0;
  logic              ev_valid;
  logic [TS_W-1:0]   ev_ts;
  logic [1:0]        ev_src;
  logic [31:0]       ev_gpio, ev_gpio1;
  logic [4:0]        level;
  logic              overflow;
  logic [15:0]       drop_cnt;
  logic              test_done, test_pass;

  gpio_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W), .DONE_MAGIC(MAGIC), .PASS_VALUE(PASSV)) dut (
    .clk(clk), .rst_n(rst_n), .gpio(gpio), .gpio1(gpio1),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_ts(ev_ts), .ev_src(ev_src),
    .ev_gpio(ev_gpio), .ev_gpio1(ev_gpio1), .level(level), .overflow(overflow),
    .drop_cnt(drop_cnt), .test_done(test_done), .test_pass(test_pass)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TS_W-1:0] ts;
    logic [1:0]      src;
    logic [31:0]     g;
    logic [31:0]     g1;
  } ev_t;

  typedef struct {
    logic [31:0] g;
    logic [31:0] g1;
    logic        rdy;
    logic [4:0]  exp_level;
    logic        exp_valid;
    logic [1:0]  exp_src;
  } vec_t;

  ev_t             sb[$];
  logic [TS_W-1:0] m_ts;
  logic [31:0]     m_prev_g, m_prev_g1;
  logic            m_ovf, m_done, m_pass;
  logic [15:0]     m_drop;
  int              n_checks = 0;
  int              n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_head(input string name);
    check({name, "_valid"}, 64'(ev_valid), 64'(1'b1));
    if (sb.size() != 0) begin
      check({name, "_ts"},    64'(ev_ts),    64'(sb[0].ts));
      check({name, "_src"},   64'(ev_src),   64'(sb[0].src));
      check({name, "_gpio"},  64'(ev_gpio),  64'(sb[0].g));
      check({name, "_gpio1"}, 64'(ev_gpio1), 64'(sb[0].g1));
    end
  endtask

  task automatic check_status(input string name);
    check({name, "_level"},    64'(level),     64'(sb.size()));
    check({name, "_valid"},    64'(ev_valid),  64'(sb.size() != 0));
    check({name, "_overflow"}, 64'(overflow),  64'(m_ovf));
    check({name, "_drop_cnt"}, 64'(drop_cnt),  64'(m_drop));
    check({name, "_done"},     64'(test_done), 64'(m_done));
    check({name, "_pass"},     64'(test_pass), 64'(m_pass));
  endtask

  // One clock cycle: the model consumes the inputs currently driven, the
  // popped head is compared against the scoreboard, then the edge happens.
  task automatic step();
    logic [1:0] chg;
    bit         pop, full;
    chg  = {gpio1 != m_prev_g1, gpio != m_prev_g};
    pop  = (sb.size() != 0) && ev_ready;
    full = (sb.size() == DEPTH);
    if (pop) begin
      check_head("pop");
      void'(sb.pop_front());
    end
    if (chg != 2'b00) begin
      if (!full || pop) sb.push_back('{m_ts, chg, gpio, gpio1});
      else begin
        m_ovf = 1'b1;
        if (m_drop != 16'hFFFF) m_drop++;
      end
    end
    if (!m_done && gpio == MAGIC) begin
      m_done = 1'b1;
      m_pass = (gpio1 == PASSV);
    end
    m_prev_g  = gpio;
    m_prev_g1 = gpio1;
    @(posedge clk);
    #1;
    if (m_ts != '1) m_ts++;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    gpio     = '0;
    gpio1    = '0;
    ev_ready = 1'b0;
    sb.delete();
    m_ts = '0; m_prev_g = '0; m_prev_g1 = '0;
    m_ovf = 1'b0; m_drop = '0; m_done = 1'b0; m_pass = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_status("in_reset");
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t            vecs[7];
    logic [TS_W-1:0] last_ts;

    vecs[0] = '{32'hA, 32'hB, 1'b0, 5'd1, 1'b1, 2'b11};
    vecs[1] = '{32'hA, 32'hB, 1'b0, 5'd1, 1'b1, 2'b11};
    vecs[2] = '{32'hA, 32'hC, 1'b0, 5'd2, 1'b1, 2'b11};
    vecs[3] = '{32'hA, 32'hC, 1'b1, 5'd1, 1'b1, 2'b10};
    vecs[4] = '{32'h7, 32'hC, 1'b1, 5'd1, 1'b1, 2'b01};
    vecs[5] = '{32'h7, 32'hC, 1'b1, 5'd0, 1'b0, 2'b00};
    vecs[6] = '{32'h7, 32'hC, 1'b1, 5'd0, 1'b0, 2'b00};

    // Idle after reset: nothing logged for 20 cycles.
    do_reset();
    repeat (20) step();
    check_status("idle");
    check("idle_level", 64'(level), 64'd0);

    // Single gpio change in cycle 3 appears in cycle 4 with ts=3.
    do_reset();
    repeat (3) step();
    gpio = 32'h5; ev_ready = 1'b1;
    step();
    check("first_valid", 64'(ev_valid), 64'd1);
    check("first_ts",    64'(ev_ts),    64'd3);
    check("first_src",   64'(ev_src),   64'b01);
    check("first_gpio",  64'(ev_gpio),  64'h5);
    check("first_gpio1", 64'(ev_gpio1), 64'h0);
    step();
    check("first_popped_level", 64'(level), 64'd0);

    // Table: dual-port change, stall, push+pop, empty with ready.
    for (int i = 0; i < 7; i++) begin
      gpio = vecs[i].g; gpio1 = vecs[i].g1; ev_ready = vecs[i].rdy;
      step();
      check_status($sformatf("vec%0d", i));
      check($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].exp_level));
      check($sformatf("vec%0d_valid", i), 64'(ev_valid), 64'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) check($sformatf("vec%0d_src", i), 64'(ev_src), 64'(vecs[i].exp_src));
    end

    // Overflow: 19 changes with the consumer stalled.
    do_reset();
    for (int v = 1; v <= 19; v++) begin
      gpio = v;
      step();
    end
    check_status("ovf");
    check("ovf_level", 64'(level), 64'd16);
    check("ovf_flag",  64'(overflow), 64'd1);
    check("ovf_drops", 64'(drop_cnt), 64'd3);
    repeat (3) begin
      step();
      check_head("stall");
      check("stall_head_gpio", 64'(ev_gpio), 64'd1);
    end

    // Full FIFO with simultaneous push and pop, then drain in order.
    gpio = 32'd100; ev_ready = 1'b1;
    step();
    check_status("full_pushpop");
    check("full_pushpop_level", 64'(level), 64'd16);
    check("full_pushpop_drops", 64'(drop_cnt), 64'd3);
    last_ts = '0;
    for (int k = 0; k < 16; k++) begin
      check("drain_gpio", 64'(ev_gpio), (k < 15) ? 64'(k + 2) : 64'd100);
      if (k > 0) check("drain_ts_incr", 64'(ev_ts > last_ts), 64'd1);
      last_ts = ev_ts;
      step();
    end
    check_status("drained");
    check("drained_level", 64'(level), 64'd0);

    // End-of-test handshake with pass, then later writes ignored.
    do_reset();
    ev_ready = 1'b1;
    gpio1 = 32'h1; step();
    gpio = MAGIC;  step();
    check("done_set",  64'(test_done), 64'd1);
    check("pass_set",  64'(test_pass), 64'd1);
    gpio1 = 32'h0; step();
    gpio = 32'h0;  step();
    gpio = MAGIC;  step();
    check_status("done_frozen");
    check("pass_frozen", 64'(test_pass), 64'd1);

    // Second run fails the handshake.
    do_reset();
    ev_ready = 1'b1;
    gpio1 = 32'h2; step();
    gpio = MAGIC;  step();
    check_status("fail_run");
    check("fail_done", 64'(test_done), 64'd1);
    check("fail_pass", 64'(test_pass), 64'd0);

    // Reset mid-drain with five queued entries.
    do_reset();
    for (int v = 1; v <= 5; v++) begin
      gpio = v;
      step();
    end
    check("pre_reset_level", 64'(level), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_valid", 64'(ev_valid), 64'd0);
    check("async_reset_level", 64'(level), 64'd0);
    do_reset();
    check("post_reset_drops", 64'(drop_cnt), 64'd0);
    gpio = 32'h55;
    step();
    check("restart_ts", 64'(ev_ts), 64'd0);
    check_head("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
